// File: rtl/jesd204_rx_lane_deskew.sv
// Multi-lane JESD204B RX deskew buffer: each lane is buffered from its first K28.0
// marker, and all enabled lanes are released together once every lane has marked.
`timescale 1ns/1ps
module jesd204_rx_lane_deskew #(
  parameter int         LANES         = 4,
  parameter int         DW            = 32,
  parameter int         DEPTH         = 16,
  parameter logic [7:0] MARK_CHAR     = 8'h1C,
  parameter int         RELEASE_DELAY = 0,
  localparam int        OCT           = DW / 8,
  localparam int        SW            = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [LANES-1:0]       LANE_EN,
  input  logic [LANES-1:0]       IN_VALID,
  input  logic [LANES*DW-1:0]    IN_DATA,
  input  logic [LANES*OCT-1:0]   IN_CHARISK,
  output logic                   OUT_VALID,
  output logic [LANES*DW-1:0]    OUT_DATA,
  output logic                   ALIGNED,
  output logic                   ALIGN_ERR,
  output logic [LANES*SW-1:0]    LANE_SKEW
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              HW        = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'((RELEASE_DELAY > 0) ? RELEASE_DELAY - 1 : 0);
  localparam logic [SW-1:0]   SKEW_MAX  = SW'(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_MARK, HOLD, RUN, ERROR} state_t;

  state_t            state, state_nxt;
  logic [LANES-1:0]  lane_en_q, mark_q;
  logic [LANES-1:0]  is_marker, wr_req, wr_en, full, empty;
  logic [AW:0]       wr_ptr [LANES];
  logic [AW:0]       rd_ptr [LANES];
  logic [DW-1:0]     mem    [LANES][DEPTH];
  logic [SW-1:0]     skew   [LANES];
  logic [HW-1:0]     hold_cnt;
  logic              all_marked, rd_en, overflow, underflow, flush;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    is_marker = '0;
    full      = '0;
    empty     = '0;
    wr_req    = '0;
    for (int i = 0; i < LANES; i++) begin
      is_marker[i] = IN_VALID[i] && IN_CHARISK[i*OCT] && (IN_DATA[i*DW +: 8] == MARK_CHAR);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) && (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      // Before its marker a lane discards words; afterwards every valid word is kept.
      if (lane_en_q[i] && IN_VALID[i]) begin
        if (state == WAIT_MARK)
          wr_req[i] = mark_q[i] || is_marker[i];
        else
          wr_req[i] = (state == HOLD) || (state == RUN);
      end
    end
  end

  assign all_marked = &(mark_q | ~lane_en_q);
  assign underflow  = ENABLE && (state == RUN) && |(empty & lane_en_q);
  assign rd_en      = ENABLE && (state == RUN) && !underflow;
  assign overflow   = ENABLE && |(wr_req & full & ~{LANES{rd_en}});
  assign wr_en      = wr_req & (~full | {LANES{rd_en}});
  assign flush      = !ENABLE || (state == IDLE);
  assign ALIGNED    = (state == RUN);

  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = IDLE;
    end else if (overflow || underflow) begin
      state_nxt = ERROR;
    end else begin
      unique case (state)
        IDLE:      if (|LANE_EN) state_nxt = WAIT_MARK;
        WAIT_MARK: if (all_marked) state_nxt = (RELEASE_DELAY > 0) ? HOLD : RUN;
        HOLD:      if (hold_cnt == HOLD_LAST) state_nxt = RUN;
        default:   state_nxt = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane_en_q <= '0;
      mark_q    <= '0;
      hold_cnt  <= '0;
      OUT_VALID <= 1'b0;
      ALIGN_ERR <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        skew[i]   <= '0;
      end
    end else begin
      OUT_VALID <= rd_en;
      if (!ENABLE)                    ALIGN_ERR <= 1'b0;
      else if (overflow || underflow) ALIGN_ERR <= 1'b1;
      if ((state == IDLE) && ENABLE && |LANE_EN) lane_en_q <= LANE_EN;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (flush) begin
        mark_q <= '0;
        for (int i = 0; i < LANES; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          skew[i]   <= '0;
        end
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if ((state == WAIT_MARK) && lane_en_q[i] && is_marker[i]) mark_q[i] <= 1'b1;
          if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (rd_en && lane_en_q[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
          // Lead accumulates only while some enabled lane is still unmarked.
          if ((state == WAIT_MARK) && !all_marked && mark_q[i] && wr_en[i] && (skew[i] != SKEW_MAX))
            skew[i] <= skew[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; only the pointers are, which keeps the
  // array free to map onto RAM.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++)
      if (wr_en[i]) mem[i][wr_ptr[i][AW-1:0]] <= IN_DATA[i*DW +: DW];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_DATA <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < LANES; i++)
        OUT_DATA[i*DW +: DW] <= lane_en_q[i] ? mem[i][rd_ptr[i][AW-1:0]] : '0;
    end
  end

  always_comb begin
    LANE_SKEW = '0;
    for (int i = 0; i < LANES; i++) LANE_SKEW[i*SW +: SW] = skew[i];
  end

endmodule
